// File: rtl/sync_fifo_stuff.sv
// rtl/sync_fifo_stuff.sv - byte-stuffing word FIFO with rollover dummy slots and status flags
// Optional peak-level tracking (hwm) is enabled by defining SYNC_FIFO_HWM_EN.
module sync_fifo_stuff #(
  parameter int DATA_W    = 91,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic              rollover_write,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_req,
  input  logic              clear_err,
  output logic [DATA_W-1:0] read_data,
  output logic              rdata_valid,
  output logic              rdata_dummy,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic [AW:0]       fill_level,
  output logic              overflow,
  output logic              underflow,
  output logic [AW:0]       hwm
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              tag [DEPTH];

  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]   cost, free_slots;
  logic [AW-1:0] wr_idx, wr_idx_1, rd_idx;
  logic          wr_ok, wr_rej, read_en;

  assign fill_level  = wr_ptr - rd_ptr;
  assign fifo_empty  = (fill_level == '0);
  assign fifo_full   = (fill_level == DEPTH_L);
  assign almost_full = (fill_level >= AF_L);

  // A rollover claims its dummy slot up front; a same-cycle read frees nothing in time.
  assign cost       = rollover_write ? (AW+1)'(2) : (AW+1)'(1);
  assign free_slots = DEPTH_L - fill_level;
  assign wr_ok      = write_enable & (free_slots >= cost);
  assign wr_rej     = write_enable & ~wr_ok;
  assign read_en    = read_req & ~fifo_empty;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign wr_idx_1 = wr_ptr[AW-1:0] + 1'b1;
  assign rd_idx   = rd_ptr[AW-1:0];

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (wr_ok)   wr_ptr_nxt = wr_ptr + cost;
    if (read_en) rd_ptr_nxt = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= write_data;
      tag[wr_idx] <= 1'b0;
      if (rollover_write) tag[wr_idx_1] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      read_data   <= '0;
      rdata_valid <= 1'b0;
      rdata_dummy <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      rdata_valid <= read_en;
      if (read_en) begin
        read_data   <= tag[rd_idx] ? '0 : mem[rd_idx];
        rdata_dummy <= tag[rd_idx];
      end
      // A fresh error outranks a clear in the same cycle.
      if (wr_rej)         overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (read_req && fifo_empty) underflow <= 1'b1;
      else if (clear_err)         underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_HWM_EN
  logic [AW:0] next_fill;
  logic [AW:0] hwm_q;

  assign next_fill = wr_ptr_nxt - rd_ptr_nxt;
  assign hwm       = hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hwm_q <= '0;
    else if (clear_err)          hwm_q <= fill_level;
    else if (next_fill > hwm_q)  hwm_q <= next_fill;
  end
`else
  assign hwm = '0;
`endif

endmodule
